// File: rtl/coin_acceptor.sv
// ============================================================================
// Module   : coin_acceptor
// Purpose  : Synchronises and debounces three coin sensors, queues accepted
//            coins and hands them to the coin machine one per ready cycle.
//            Optional running tally of accepted cents: COIN_ACCEPTOR_TALLY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          nickelSense,
  input  logic                          dimeSense,
  input  logic                          quarterSense,
  input  logic                          ready,
  output logic                          nickel,
  output logic                          dime,
  output logic                          quarter,
  output logic                          coinReject,
`ifdef COIN_ACCEPTOR_TALLY_EN
  output logic [15:0]                   totalCents,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   queueCount
);

  localparam int                 c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [7:0]         c_DB_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PTR_W:0]   c_FULL   = (c_PTR_W + 1)'(FIFO_DEPTH);

  // Channel order everywhere: bit 0 nickel, bit 1 dime, bit 2 quarter
  logic [2:0]         w_sense;
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [2:0]         r_level;
  logic [2:0]         r_level_q;
  logic [7:0]         r_cnt [3];

  logic [2:0]         w_evt;
  logic               w_one;
  logic               w_multi;
  logic [1:0]         w_code;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [1:0]         w_head;

  logic [1:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;

  assign w_sense = {quarterSense, dimeSense, nickelSense};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_sense;
      r_sync2 <= r_sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level   <= '0;
      r_level_q <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_level_q <= r_level;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_DB_MAX) begin
          r_level[i] <= ~r_level[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_evt   = r_level & ~r_level_q;
  assign w_one   = $onehot(w_evt);
  assign w_multi = (w_evt != 3'b000) && !w_one;
  assign w_code  = w_evt[0] ? 2'd0 : (w_evt[1] ? 2'd1 : 2'd2);

  assign w_full  = (r_count == c_FULL);
  assign w_pop   = (r_count != '0) && ready;
  // A pop in the same cycle frees the slot a full-queue push needs
  assign w_push  = w_one && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign nickel     = w_pop && (w_head == 2'd0);
  assign dime       = w_pop && (w_head == 2'd1);
  assign quarter    = w_pop && (w_head == 2'd2);
  assign coinReject = w_multi || (w_one && w_full && !w_pop);
  assign queueCount = r_count;

`ifdef COIN_ACCEPTOR_TALLY_EN
  logic [15:0] r_total;
  logic [4:0]  w_add;
  logic [16:0] w_sum;

  assign w_add = nickel ? 5'd5 : (dime ? 5'd10 : (quarter ? 5'd25 : 5'd0));
  assign w_sum = {1'b0, r_total} + {12'd0, w_add};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_total <= '0;
    else       r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  assign totalCents = r_total;
`endif

endmodule

`default_nettype wire

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to change a debounced level (2..255).
- FIFO_DEPTH, 4, coin queue entries (power of two, 2..16).
REQ-002 The block SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- nickelSense  input  1  raw, asynchronous, bouncy nickel sensor.
- dimeSense  input  1  raw dime sensor, same properties.
- quarterSense  input  1  raw quarter sensor, same properties.
- ready  input  1  coin machine can take a coin this cycle.
- nickel  output  1  one-cycle nickel pulse to the coin machine.
- dime  output  1  one-cycle dime pulse.
- quarter  output  1  one-cycle quarter pulse.
- coinReject  output  1  one-cycle pulse, coin discarded.
- queueCount  output  $clog2(FIFO_DEPTH)+1  coins currently queued.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 Each sense input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-005 Each channel SHALL have an 8-bit debounce counter that clears when the synchronized sample equals the debounced level, increments otherwise, and toggles the debounced level and clears itself when it reaches DEBOUNCE_CYCLES-1.
REQ-006 A coin event SHALL be a 0->1 transition of a debounced level. Release (1->0) SHALL produce no event.
REQ-007 Exactly one event in a cycle SHALL push a 2-bit code into the FIFO: 0 = nickel, 1 = dime, 2 = quarter.
REQ-008 Two or more events in the same cycle SHALL push nothing and SHALL pulse coinReject for one cycle.
REQ-009 An event while the FIFO is full SHALL be dropped and SHALL pulse coinReject, unless a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-010 When the FIFO is non-empty and ready=1, the head SHALL pop. The matching output (nickel, dime or quarter) SHALL be high for exactly one cycle, in the same cycle as the pop (combinational on head and ready).
REQ-011 At most one of nickel, dime and quarter SHALL be high in any cycle. All three SHALL be low when the FIFO is empty or ready=0.
REQ-012 A coin pushed into an empty FIFO SHALL be poppable no earlier than the next cycle; there SHALL be no push-to-output bypass.
REQ-013 Latency from a sense rising edge to the output pulse SHALL be 2 (synchronizer) + DEBOUNCE_CYCLES + 1 (push) cycles when ready is high.
REQ-014 queueCount SHALL equal pushes minus pops. It SHALL never exceed FIFO_DEPTH or go below zero. Read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-015 Asserting reset SHALL, without waiting for a clock edge, clear the synchronizers, debounced levels, counters, pointers, queueCount and all outputs to 0.
REQ-016 Reset asserted mid-debounce or with a non-empty queue SHALL discard all partial and queued coins. Once reset releases, a sense held high SHALL count as a new event after the full debounce period.

Configuration
REQ-017 With macro COIN_ACCEPTOR_TALLY_EN defined, the block SHALL add output totalCents [15:0]. It SHALL add 5, 10 or 25 on each nickel, dime or quarter output pulse, saturate at 65535 and reset to 0.
REQ-018 Without COIN_ACCEPTOR_TALLY_EN, the totalCents port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-019 Test: DEBOUNCE_CYCLES=16, ready=1, nickelSense high for 50 cycles -> exactly one nickel pulse, 19 cycles after the rising edge; no pulse on release.
REQ-020 Test: dimeSense toggles every 3 cycles for 40 cycles, then holds high -> no pulse during toggling; exactly one dime pulse after stable high.
REQ-021 Test: ready=0; quarter, dime, nickel, dime, quarter inserted sequentially -> queueCount=4 and the 5th coin gives one coinReject pulse. Then ready=1 -> quarter, dime, nickel, dime pulses on consecutive cycles, and queueCount reaches 0.
REQ-022 Test: nickelSense and quarterSense rise in the same cycle -> one coinReject pulse, no push, queueCount unchanged.
REQ-023 Test: reset pulsed for 1 cycle with 3 coins queued and dimeSense mid-debounce -> all outputs 0, queueCount=0; dime pulse only after a full new debounce period.
REQ-024 Test (COIN_ACCEPTOR_TALLY_EN): nickel, dime, quarter, quarter accepted -> totalCents=65; preload near 65535 then add a quarter -> totalCents stays 65535.
